// File: rtl/bcd_pkg.sv
// ============================================================================
// Module : bcd_pkg
// Brief  : Shared types and helpers for the sequential binary-to-BCD converter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Decimal digit count of 2^bin_w-1; DIGITS at or above this never overflows.
    function automatic int min_digits(input int bin_w);
        logic [63:0] v;
        int          n;
        v = (64'd1 << bin_w) - 64'd1;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            if (v >= 64'd10) begin
                v = v / 64'd10;
                n = n + 1;
            end
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// ============================================================================
// Module : bcd_digit_adj
// Brief  : Single BCD digit pre-shift correction: add 3 when the digit is >= 5.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    always_comb begin
        if (digit_in >= BCD_DIGIT_W'(5)) begin
            digit_out = digit_in + BCD_DIGIT_W'(3);
        end else begin
            digit_out = digit_in;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
// ============================================================================
// Module : bin_to_bcd_seq
// Brief  : Bit-serial double-dabble binary-to-BCD converter with blank mask
//          and saturating overflow flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  ovf
);

    localparam int                  c_scr_w     = BCD_DIGIT_W * DIGITS;
    localparam int                  c_cnt_w     = $clog2(BIN_W + 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_load  = c_cnt_w'(BIN_W);
    localparam logic [c_scr_w-1:0]  c_sat       = {DIGITS{4'h9}};
    localparam logic [DIGITS-1:0]   c_blank_rst = ~DIGITS'(1);

    conv_state_t          r_state;
    conv_state_t          w_next_state;
    logic [BIN_W-1:0]     r_shift;
    logic [c_scr_w-1:0]   r_scratch;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_ovf_int;
    logic [c_scr_w-1:0]   w_adj;
    logic [DIGITS-1:0]    w_blank;
    logic                 w_zero_run;

    assign ready = (r_state == IDLE);
    assign busy  = (r_state == SHIFT);

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_adj u_adj (
            .digit_in  (r_scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = SHIFT;
            SHIFT:   if (r_cnt == c_cnt_w'(1)) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // A digit is blanked only if it and every more significant digit are zero.
    always_comb begin
        w_blank    = '0;
        w_zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zero_run = w_zero_run && (r_scratch[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            w_blank[i] = w_zero_run;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_ovf_int <= 1'b0;
            bcd       <= '0;
            blank     <= c_blank_rst;
            ovf       <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shift   <= bin;
                        r_scratch <= '0;
                        r_ovf_int <= 1'b0;
                        r_cnt     <= c_cnt_load;
                    end
                end
                SHIFT: begin
                    r_scratch <= {w_adj[c_scr_w-2:0], r_shift[BIN_W-1]};
                    r_shift   <= r_shift << 1;
                    // A 1 leaving the top digit means the value needs more digits.
                    if (w_adj[c_scr_w-1]) begin
                        r_ovf_int <= 1'b1;
                    end
                    r_cnt <= r_cnt - c_cnt_w'(1);
                end
                DONE: begin
                    bcd   <= r_ovf_int ? c_sat : r_scratch;
                    blank <= r_ovf_int ? '0 : w_blank;
                    ovf   <= r_ovf_int;
                    done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
